mem_stage_access: RTL and testbench

- MEM-stage data-memory access unit; producer side of the MEM/WB pipeline register.
- Takes EX/MEM outputs and runs loads/stores over a req/ack data-memory bus with byte/half/word sizing.
- Drives mem_wreg/mem_m2reg/mem_mo/mem_alu/mem_rn into MEM/WB, plus a pipeline stall.
- MEM/WB has no enable, so this block emits bubbles (mem_wreg=0, mem_m2reg=0) while stalled and presents each result exactly once.

---
 rtl/mem_stage_access_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_stage_access.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_access.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
// Used by mem_stage_access and mem_lane_align.
package mem_stage_access_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables/data replication and
// load lane extraction with optional sign extension; also flags misalignment.
module mem_lane_align
    import mem_stage_access_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [31:0] i_b,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_mo,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Size 2'b11 falls through to the word defaults.
    always_comb begin
        o_wdata    = i_b;
        o_be       = 4'b1111;
        o_mo       = i_rdata;
        o_misalign = (i_addr_lo != 2'b00);
        case (i_size)
            SZ_HALF: begin
                o_wdata    = {2{i_b[15:0]}};
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_mo       = {{16{i_sext & w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            SZ_BYTE: begin
                o_wdata    = {4{i_b[7:0]}};
                o_be       = 4'b0001 << i_addr_lo;
                o_mo       = {{24{i_sext & w_byte[7]}}, w_byte};
                o_misalign = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage load/store unit feeding an enable-less MEM/WB register.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_b,
    input  logic [4:0]  ex_rn,
    input  logic [1:0]  ex_size,
    input  logic        ex_sext,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_wreg,
    output logic        mem_m2reg,
    output logic [31:0] mem_mo,
    output logic [31:0] mem_alu,
    output logic [4:0]  mem_rn,
    output logic        mem_stall,
    output logic        mem_misalign
);

    state_t      r_state;
    logic [31:0] r_alu;
    logic [31:0] r_mo;
    logic [4:0]  r_rn;
    logic [1:0]  r_size;
    logic        r_wreg;
    logic        r_m2reg;
    logic        r_sext;
    logic        r_err;

    logic        w_memop;
    logic        w_in_req;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_mo;
    logic        w_mis;
    logic        w_timeout;
    logic        w_stall;
    logic        w_misal;

    assign w_memop  = ex_m2reg | ex_wmem;
    assign w_in_req = (r_state == ST_REQ);

    // While waiting for ack the lane unit decodes the captured access, not EX/MEM.
    mem_lane_align u_lane (
        .i_addr_lo  (w_in_req ? r_alu[1:0] : ex_alu[1:0]),
        .i_size     (w_in_req ? r_size     : ex_size),
        .i_sext     (w_in_req ? r_sext     : ex_sext),
        .i_b        (ex_b),
        .i_rdata    (dm_rdata),
        .o_wdata    (w_wdata),
        .o_be       (w_be),
        .o_mo       (w_mo),
        .o_misalign (w_mis)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_wait;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_wait <= 8'd0;
        else if (r_state == ST_REQ)
            r_wait <= r_wait + 8'd1;
        else
            r_wait <= 8'd0;
    end

    assign w_timeout = w_in_req && !dm_ack && (r_wait == 8'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= ST_IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'd0;
            dm_wdata <= 32'd0;
            dm_be    <= 4'd0;
            r_alu    <= 32'd0;
            r_mo     <= 32'd0;
            r_rn     <= 5'd0;
            r_size   <= 2'd0;
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_sext   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_memop && !w_mis) begin
                        r_state  <= ST_REQ;
                        dm_req   <= 1'b1;
                        dm_we    <= ex_wmem;
                        dm_addr  <= {ex_alu[31:2], 2'b00};
                        dm_wdata <= w_wdata;
                        dm_be    <= w_be;
                        r_alu    <= ex_alu;
                        r_rn     <= ex_rn;
                        r_size   <= ex_size;
                        r_wreg   <= ex_wreg;
                        r_m2reg  <= ex_m2reg;
                        r_sext   <= ex_sext;
                        r_mo     <= 32'd0;
                        r_err    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        dm_req  <= 1'b0;
                        r_mo    <= r_m2reg ? w_mo : 32'd0;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        dm_req  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bubbles while stalled; the captured result is shown only in DONE.
    always_comb begin
        mem_wreg  = ex_wreg;
        mem_m2reg = ex_m2reg;
        mem_mo    = 32'd0;
        mem_alu   = ex_alu;
        mem_rn    = ex_rn;
        w_stall   = 1'b0;
        w_misal   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    mem_wreg  = 1'b0;
                    mem_m2reg = 1'b0;
                    w_misal   = w_mis;
                    w_stall   = !w_mis;
                end
            end
            ST_REQ: begin
                mem_wreg  = 1'b0;
                mem_m2reg = 1'b0;
                mem_alu   = r_alu;
                mem_rn    = r_rn;
                w_stall   = 1'b1;
            end
            ST_DONE: begin
                mem_wreg  = r_wreg & ~r_err;
                mem_m2reg = r_m2reg & ~r_err;
                mem_mo    = r_mo;
                mem_alu   = r_alu;
                mem_rn    = r_rn;
                w_misal   = r_err;
            end
            default: ;
        endcase
    end

    assign mem_stall    = w_stall & clrn;
    assign mem_misalign = w_misal & clrn;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed table, random ops
// against a behavioural model, reset-in-REQ and (with MEM_TIMEOUT_EN) timeout.
module tb_mem_stage_access;
    import mem_stage_access_pkg::*;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 16;
`endif

    logic        clk = 1'b0;
    logic        clrn;
    logic        ex_wreg, ex_m2reg, ex_wmem, ex_sext;
    logic [31:0] ex_alu, ex_b;
    logic [4:0]  ex_rn;
    logic [1:0]  ex_size;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_wreg, mem_m2reg, mem_stall, mem_misalign;
    logic [31:0] mem_mo, mem_alu;
    logic [4:0]  mem_rn;

    int n_vec = 0;
    int n_err = 0;

    mem_stage_access #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .clrn(clrn),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_alu(ex_alu), .ex_b(ex_b), .ex_rn(ex_rn), .ex_size(ex_size), .ex_sext(ex_sext),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_mo(mem_mo), .mem_alu(mem_alu),
        .mem_rn(mem_rn), .mem_stall(mem_stall), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] mo;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        mis;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Behavioural reference: byte/half/word rules from plain arithmetic.
    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == SZ_BYTE) return 1'b0;
        if (sz == SZ_HALF) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == SZ_BYTE) return 4'(1 << off);
        if (sz == SZ_HALF) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] b);
        if (sz == SZ_BYTE) return (b & 32'hFF) * 32'h0101_0101;
        if (sz == SZ_HALF) return (b & 32'hFFFF) * 32'h0001_0001;
        return b;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input logic sx, input logic [31:0] rd);
        logic [31:0] v;
        int off = int'(a % 4);
        if (sz == SZ_BYTE) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == SZ_HALF) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic drive_nop();
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b0; ex_sext = 1'b0;
        ex_alu = $urandom; ex_b = $urandom; ex_rn = 5'd0; ex_size = SZ_WORD;
    endtask

    task automatic run_op(input vec_t v);
        int stalls;
        @(posedge clk); #1;
        ex_wreg = v.wreg; ex_m2reg = v.m2reg; ex_wmem = v.wmem; ex_alu = v.alu;
        ex_b = v.b; ex_rn = v.rn; ex_size = v.size; ex_sext = v.sext; dm_ack = 1'b0;
        @(negedge clk);
        if (!(v.m2reg || v.wmem)) begin
            chk("pass_wreg", 32'(mem_wreg), 32'(v.wreg));
            chk("pass_alu", mem_alu, v.alu);
            chk("pass_rn", 32'(mem_rn), 32'(v.rn));
            chk("pass_mo", mem_mo, 32'd0);
            chk("pass_stall", 32'(mem_stall), 32'd0);
            chk("pass_req", 32'(dm_req), 32'd0);
        end else if (v.mis) begin
            chk("mis_flag", 32'(mem_misalign), 32'd1);
            chk("mis_stall", 32'(mem_stall), 32'd0);
            chk("mis_squash", 32'({mem_wreg, mem_m2reg}), 32'd0);
            chk("mis_req", 32'(dm_req), 32'd0);
            @(posedge clk); #1; drive_nop();
            @(negedge clk);
            chk("mis_after_req", 32'(dm_req), 32'd0);
        end else begin
            chk("idle_stall", 32'(mem_stall), 32'd1);
            chk("idle_bubble", 32'({mem_wreg, mem_m2reg}), 32'd0);
            chk("idle_req", 32'(dm_req), 32'd0);
            stalls = 1;
            for (int k = 0; k <= v.waits; k++) begin
                @(posedge clk); #1;
                dm_ack   = (k == v.waits);
                dm_rdata = (k == v.waits) ? v.rdata : $urandom;
                @(negedge clk);
                stalls += int'(mem_stall);
                chk("req_req", 32'(dm_req), 32'd1);
                chk("req_bubble", 32'({mem_wreg, mem_m2reg}), 32'd0);
                chk("req_addr", dm_addr, v.alu & 32'hFFFF_FFFC);
                chk("req_be", 32'(dm_be), 32'(v.be));
                chk("req_we", 32'(dm_we), 32'(v.wmem));
                if (v.wmem) chk("req_wdata", dm_wdata, v.wd);
            end
            @(posedge clk); #1;
            dm_ack = 1'b0; dm_rdata = $urandom;
            @(negedge clk);
            stalls += int'(mem_stall);
            chk("stall_cycles", 32'(stalls), 32'(v.waits + 2));
            chk("done_wreg", 32'(mem_wreg), 32'(v.wreg));
            chk("done_m2reg", 32'(mem_m2reg), 32'(v.m2reg));
            chk("done_mo", mem_mo, v.mo);
            chk("done_alu", mem_alu, v.alu);
            chk("done_rn", 32'(mem_rn), 32'(v.rn));
            chk("done_mis", 32'(mem_misalign), 32'd0);
            chk("done_req", 32'(dm_req), 32'd0);
            @(posedge clk); #1; drive_nop();
            @(negedge clk);
            chk("once_wb", 32'({mem_wreg, mem_m2reg}), 32'd0);
            chk("once_stall", 32'(mem_stall), 32'd0);
        end
    endtask

    initial begin
        vec_t r;
        int kind;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, SZ_WORD, 1'b0, 32'h0, 0,
                    32'h0, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd8, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 2,
                    32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd9, SZ_BYTE, 1'b1, 32'h80FF_FF7F, 0,
                    32'hFFFF_FF80, 4'h8, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd9, SZ_BYTE, 1'b0, 32'h80FF_FF7F, 1,
                    32'h0000_0080, 4'h8, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_ABCD, 5'd0, SZ_HALF, 1'b0, 32'h0, 1,
                    32'h0, 4'hC, 32'hABCD_ABCD, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 5'd10, SZ_WORD, 1'b0, 32'h0, 0,
                    32'h0, 4'hF, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd11, SZ_HALF, 1'b1, 32'h8001_1234, 0,
                    32'hFFFF_8001, 4'hC, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0201, 32'h1234_5678, 5'd0, SZ_BYTE, 1'b0, 32'h0, 3,
                    32'h0, 4'h2, 32'h7878_7878, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 5'd12, 2'b11, 1'b1, 32'hCAFE_F00D, 0,
                    32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd13, SZ_HALF, 1'b0, 32'h0, 0,
                    32'h0, 4'h3, 32'h0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd14, SZ_HALF, 1'b0, 32'hFFFF_8001, 1,
                    32'h0000_8001, 4'h3, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 5'd0, SZ_WORD, 1'b0, 32'h0, 0,
                    32'h0, 4'hF, 32'h1122_3344, 1'b0};

        clrn = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
        drive_nop();
        #2 clrn = 1'b0;
        #1;
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_we", 32'(dm_we), 32'd0);
        chk("rst_be", 32'(dm_be), 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_mis", 32'(mem_misalign), 32'd0);
        repeat (2) @(posedge clk);
        #1 clrn = 1'b1;

        foreach (tbl[i]) run_op(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            kind    = $urandom_range(0, 2);
            r.wreg  = (kind == 1) ? 1'b1 : ((kind == 0) ? 1'($urandom) : 1'b0);
            r.m2reg = (kind == 1);
            r.wmem  = (kind == 2);
            r.size  = 2'($urandom_range(0, 3));
            r.sext  = 1'($urandom);
            r.alu   = $urandom;
            if ($urandom_range(0, 3) != 0) r.alu = (r.size == SZ_HALF) ? (r.alu & ~32'd1) :
                                                   (r.size == SZ_BYTE) ? r.alu : (r.alu & ~32'd3);
            r.b     = $urandom;
            r.rn    = 5'($urandom);
            r.rdata = $urandom;
            r.waits = $urandom_range(0, 4);
            r.mis   = (kind != 0) && model_mis(r.size, r.alu);
            r.be    = model_be(r.size, r.alu);
            r.wd    = model_wd(r.size, r.b);
            r.mo    = (kind == 1) ? model_load(r.size, r.alu, r.sext, r.rdata) : 32'd0;
            run_op(r);
        end

        // Reset while a load waits in REQ; a late ack must not produce a result.
        @(posedge clk); #1;
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wmem = 1'b0; ex_alu = 32'h300;
        ex_rn = 5'd7; ex_size = SZ_WORD; ex_sext = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", 32'(dm_req), 32'd1);
        #1 clrn = 1'b0;
        #1;
        chk("mid_rst_req", 32'(dm_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        drive_nop();
        clrn = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("late_ack_req", 32'(dm_req), 32'd0);
        chk("late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_wb", 32'({mem_wreg, mem_m2reg}), 32'd0);
        chk("late_ack_mo", mem_mo, 32'd0);
        run_op(tbl[1]);

`ifdef MEM_TIMEOUT_EN
        @(posedge clk); #1;
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wmem = 1'b0; ex_alu = 32'h400;
        ex_rn = 5'd3; ex_size = SZ_WORD; ex_sext = 1'b0; dm_ack = 1'b0;
        @(negedge clk);
        chk("to_idle_stall", 32'(mem_stall), 32'd1);
        for (int k = 0; k < TB_TO; k++) begin
            @(negedge clk);
            chk("to_req", 32'(dm_req), 32'd1);
            chk("to_stall", 32'(mem_stall), 32'd1);
        end
        @(negedge clk);
        chk("to_done_req", 32'(dm_req), 32'd0);
        chk("to_done_stall", 32'(mem_stall), 32'd0);
        chk("to_err", 32'(mem_misalign), 32'd1);
        chk("to_squash", 32'({mem_wreg, mem_m2reg}), 32'd0);
        @(posedge clk); #1; drive_nop();
        @(negedge clk);
        chk("to_err_once", 32'(mem_misalign), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
